// File: rtl/pc_seq_if.sv
// Sequencer bus: fetch handshake, decode/jump-control resolution and status.
// master = pc_seq side, slave = instruction memory / decode-stage side.
interface pc_seq_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned CNT_W  = 8
);
   logic              fetch_req;
   logic              fetch_ack;
   logic [ADDR_W-1:0] fetch_addr;
   logic              instr_valid;
   logic              dec_done;
   logic              jmp_en;
   logic [ADDR_W-1:0] jmp_target;
   logic              halt;
   logic              link_req;
   logic [ADDR_W-1:0] pc;
   logic              halted;
   logic [CNT_W-1:0]  jmp_count;
   logic [ADDR_W-1:0] link_addr;

   modport master (
      output fetch_req,
      output fetch_addr,
      output instr_valid,
      output pc,
      output halted,
      output jmp_count,
      output link_addr,
      input  fetch_ack,
      input  dec_done,
      input  jmp_en,
      input  jmp_target,
      input  halt,
      input  link_req
   );

   modport slave (
      input  fetch_req,
      input  fetch_addr,
      input  instr_valid,
      input  pc,
      input  halted,
      input  jmp_count,
      input  link_addr,
      output fetch_ack,
      output dec_done,
      output jmp_en,
      output jmp_target,
      output halt,
      output link_req
   );
endinterface

// File: rtl/pc_seq.sv
// Program-counter sequencer: IDLE -> FETCH -> DECODE loop with jumps, halt and a
// saturating taken-jump counter. Define PC_SEQ_LINK_EN to add the jump-and-link register.
module pc_seq #(
   parameter int unsigned       ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       CNT_W    = 8
) (
   input logic      clk,
   input logic      rst,
   pc_seq_if.master bus
);

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StDecode,
      StHalted
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [CNT_W-1:0]  jmp_count_q;
   logic              fetch_req_q;
   logic              instr_valid_q;
   logic              halted_q;

   logic [ADDR_W-1:0] pc_inc;
   logic              take_jump;

   assign pc_inc    = pc_q + ADDR_W'(1);
   // halt wins over jmp_en when both arrive with dec_done
   assign take_jump = (state_q == StDecode) && bus.dec_done && !bus.halt && bus.jmp_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         pc_q          <= RESET_PC;
         jmp_count_q   <= '0;
         fetch_req_q   <= 1'b0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_q     <= StFetch;
               fetch_req_q <= 1'b1;
            end
            StFetch: begin
               if (bus.fetch_ack) begin
                  state_q       <= StDecode;
                  fetch_req_q   <= 1'b0;
                  instr_valid_q <= 1'b1;
               end
            end
            StDecode: begin
               if (bus.dec_done) begin
                  instr_valid_q <= 1'b0;
                  if (bus.halt) begin
                     state_q  <= StHalted;
                     halted_q <= 1'b1;
                  end else begin
                     state_q     <= StFetch;
                     fetch_req_q <= 1'b1;
                     if (bus.jmp_en) begin
                        pc_q <= bus.jmp_target;
                        if (jmp_count_q != {CNT_W{1'b1}}) begin
                           jmp_count_q <= jmp_count_q + CNT_W'(1);
                        end
                     end else begin
                        pc_q <= pc_inc;
                     end
                  end
               end
            end
            StHalted: begin
               state_q <= StHalted;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

`ifdef PC_SEQ_LINK_EN
   logic [ADDR_W-1:0] link_addr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         link_addr_q <= '0;
      end else if (take_jump && bus.link_req) begin
         link_addr_q <= pc_inc;
      end
   end

   assign bus.link_addr = link_addr_q;
`else
   logic unused_link;

   assign unused_link   = bus.link_req ^ take_jump;
   assign bus.link_addr = '0;
`endif

   assign bus.fetch_req   = fetch_req_q;
   assign bus.fetch_addr  = pc_q;
   assign bus.pc          = pc_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.halted      = halted_q;
   assign bus.jmp_count   = jmp_count_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed self-checking bench for pc_seq (ADDR_W=8, RESET_PC=0x10, CNT_W=2).
module tb_pc_seq;

   localparam int unsigned     ADDR_W   = 8;
   localparam int unsigned     CNT_W    = 2;
   localparam logic [7:0]      RESET_PC = 8'h10;

`ifdef PC_SEQ_LINK_EN
   localparam logic [7:0] LINK_EXP = 8'h21;
`else
   localparam logic [7:0] LINK_EXP = 8'h00;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   pc_seq_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   pc_seq #(
      .ADDR_W  (ADDR_W),
      .RESET_PC(RESET_PC),
      .CNT_W   (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Sample 1 time unit after the rising edge; inputs change at the same point.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_fetch();
      bus.fetch_ack = 1'b1;
      tick();
      bus.fetch_ack = 1'b0;
   endtask

   task automatic do_decode(input logic jmp, input logic [7:0] tgt, input logic lnk,
                            input logic hlt);
      bus.dec_done   = 1'b1;
      bus.jmp_en     = jmp;
      bus.jmp_target = tgt;
      bus.link_req   = lnk;
      bus.halt       = hlt;
      tick();
      bus.dec_done   = 1'b0;
      bus.jmp_en     = 1'b0;
      bus.jmp_target = 8'h00;
      bus.link_req   = 1'b0;
      bus.halt       = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      rst            = 1'b1;
      bus.fetch_ack  = 1'b0;
      bus.dec_done   = 1'b0;
      bus.jmp_en     = 1'b0;
      bus.jmp_target = 8'h00;
      bus.halt       = 1'b0;
      bus.link_req   = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_fetch_req",   32'(bus.fetch_req),   32'd0);
      chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_halted",      32'(bus.halted),      32'd0);
      chk("rst_fetch_addr",  32'(bus.fetch_addr),  32'h10);
      chk("rst_jmp_count",   32'(bus.jmp_count),   32'd0);
      chk("rst_link_addr",   32'(bus.link_addr),   32'd0);

      // Release: IDLE cycle, then FETCH at RESET_PC
      rst = 1'b0;
      chk("idle_fetch_req", 32'(bus.fetch_req), 32'd0);
      tick();
      chk("first_fetch_req",  32'(bus.fetch_req),  32'd1);
      chk("first_fetch_addr", 32'(bus.fetch_addr), 32'h10);

      // FETCH waits for ack; stray dec_done ignored
      bus.dec_done = 1'b1;
      bus.jmp_en   = 1'b1;
      bus.jmp_target = 8'h99;
      tick();
      bus.dec_done = 1'b0;
      bus.jmp_en   = 1'b0;
      bus.jmp_target = 8'h00;
      chk("fetch_wait_req",   32'(bus.fetch_req),   32'd1);
      chk("fetch_wait_valid", 32'(bus.instr_valid), 32'd0);
      chk("fetch_wait_pc",    32'(bus.pc),          32'h10);
      chk("fetch_wait_cnt",   32'(bus.jmp_count),   32'd0);

      // Into DECODE; stray fetch_ack ignored
      do_fetch();
      chk("dec_valid", 32'(bus.instr_valid), 32'd1);
      chk("dec_req",   32'(bus.fetch_req),   32'd0);
      bus.fetch_ack = 1'b1;
      tick();
      bus.fetch_ack = 1'b0;
      chk("dec_hold_valid", 32'(bus.instr_valid), 32'd1);
      chk("dec_hold_pc",    32'(bus.pc),          32'h10);

      // Jump #1 to 0xFF, then sequential wrap to 0x00
      do_decode(1'b1, 8'hFF, 1'b0, 1'b0);
      chk("j1_pc",  32'(bus.pc),        32'hFF);
      chk("j1_cnt", 32'(bus.jmp_count), 32'd1);
      chk("j1_link", 32'(bus.link_addr), 32'd0);
      do_fetch();
      do_decode(1'b0, 8'h00, 1'b0, 1'b0);
      chk("wrap_pc",   32'(bus.pc),        32'h00);
      chk("wrap_req",  32'(bus.fetch_req), 32'd1);
      chk("wrap_addr", 32'(bus.fetch_addr), 32'h00);
      chk("wrap_cnt",  32'(bus.jmp_count), 32'd1);

      // Jump #2 to 0x20, jump #3 with link from 0x20 to 0x05
      do_fetch();
      do_decode(1'b1, 8'h20, 1'b0, 1'b0);
      chk("j2_pc",  32'(bus.pc),        32'h20);
      chk("j2_cnt", 32'(bus.jmp_count), 32'd2);
      do_fetch();
      do_decode(1'b1, 8'h05, 1'b1, 1'b0);
      chk("j3_pc",   32'(bus.pc),        32'h05);
      chk("j3_cnt",  32'(bus.jmp_count), 32'd3);
      chk("j3_link", 32'(bus.link_addr), 32'(LINK_EXP));

      // Jumps #4, #5 saturate; link holds without link_req
      do_fetch();
      do_decode(1'b1, 8'h40, 1'b0, 1'b0);
      chk("j4_pc",   32'(bus.pc),        32'h40);
      chk("j4_cnt",  32'(bus.jmp_count), 32'd3);
      chk("j4_link", 32'(bus.link_addr), 32'(LINK_EXP));
      do_fetch();
      do_decode(1'b1, 8'h41, 1'b0, 1'b0);
      chk("j5_cnt", 32'(bus.jmp_count), 32'd3);

      // Halt has priority over jmp_en
      do_reset();
      do_fetch();
      do_decode(1'b1, 8'h30, 1'b0, 1'b0);
      chk("h_pre_cnt", 32'(bus.jmp_count), 32'd1);
      do_fetch();
      do_decode(1'b1, 8'h55, 1'b1, 1'b1);
      chk("h_halted", 32'(bus.halted),      32'd1);
      chk("h_pc",     32'(bus.pc),          32'h30);
      chk("h_cnt",    32'(bus.jmp_count),   32'd1);
      chk("h_req",    32'(bus.fetch_req),   32'd0);
      chk("h_valid",  32'(bus.instr_valid), 32'd0);
      chk("h_link",   32'(bus.link_addr),   32'd0);
      do_fetch();
      do_decode(1'b1, 8'h66, 1'b0, 1'b0);
      do_fetch();
      chk("h_stay_halted", 32'(bus.halted),    32'd1);
      chk("h_stay_pc",     32'(bus.pc),        32'h30);
      chk("h_stay_cnt",    32'(bus.jmp_count), 32'd1);
      chk("h_stay_req",    32'(bus.fetch_req), 32'd0);

      // Reset beats a same-edge jump in DECODE
      do_reset();
      do_fetch();
      do_decode(1'b1, 8'h20, 1'b1, 1'b0);
      chk("r_pre_cnt", 32'(bus.jmp_count), 32'd1);
      do_fetch();
      chk("r_pre_valid", 32'(bus.instr_valid), 32'd1);
      rst            = 1'b1;
      bus.dec_done   = 1'b1;
      bus.jmp_en     = 1'b1;
      bus.jmp_target = 8'h77;
      bus.link_req   = 1'b1;
      tick();
      bus.dec_done   = 1'b0;
      bus.jmp_en     = 1'b0;
      bus.jmp_target = 8'h00;
      bus.link_req   = 1'b0;
      chk("r_pc",     32'(bus.pc),          32'h10);
      chk("r_cnt",    32'(bus.jmp_count),   32'd0);
      chk("r_link",   32'(bus.link_addr),   32'd0);
      chk("r_valid",  32'(bus.instr_valid), 32'd0);
      chk("r_req",    32'(bus.fetch_req),   32'd0);
      chk("r_halted", 32'(bus.halted),      32'd0);
      rst = 1'b0;
      chk("r_idle_req", 32'(bus.fetch_req), 32'd0);
      tick();
      chk("r_fetch_req",  32'(bus.fetch_req),  32'd1);
      chk("r_fetch_addr", 32'(bus.fetch_addr), 32'h10);

      // Minimum 2-cycle instruction period
      bus.fetch_ack = 1'b1;
      tick();
      bus.fetch_ack = 1'b0;
      bus.dec_done  = 1'b1;
      tick();
      bus.dec_done  = 1'b0;
      chk("min_pc",  32'(bus.pc),        32'h11);
      chk("min_req", 32'(bus.fetch_req), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter ADDR_W, default 8: width of program counter and fetch/jump addresses.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 Parameter CNT_W, default 8: width of the taken-jump counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 fetch_req  output  1  fetch request to instruction memory.
REQ-007 fetch_ack  input  1  instruction memory has returned the word for fetch_addr.
REQ-008 fetch_addr  output  ADDR_W  address being fetched; equals pc.
REQ-009 instr_valid  output  1  fetched instruction held for the decode/jump-control stage.
REQ-010 dec_done  input  1  decode/jump-control stage has resolved the current instruction.
REQ-011 jmp_en  input  1  jump-taken decision from the jump-control stage; sampled only with dec_done.
REQ-012 jmp_target  input  ADDR_W  jump destination; sampled only with dec_done and jmp_en.
REQ-013 halt  input  1  current instruction is HALT; sampled only with dec_done.
REQ-014 link_req  input  1  current jump is jump-and-link; sampled only with dec_done and jmp_en.
REQ-015 pc  output  ADDR_W  current program counter.
REQ-016 halted  output  1  sequencer is in HALTED.
REQ-017 jmp_count  output  CNT_W  count of taken jumps since reset.
REQ-018 link_addr  output  ADDR_W  saved return address.

Function
REQ-019 States IDLE, FETCH, DECODE, HALTED, held in a state register; all outputs decoded from registered state and registers only.
REQ-020 IDLE: fetch_req=0, instr_valid=0; next state FETCH unconditionally.
REQ-021 FETCH: fetch_req=1, fetch_addr=pc; on fetch_ack=1 next state DECODE, else remain FETCH.
REQ-022 DECODE: instr_valid=1, fetch_req=0; remain DECODE while dec_done=0.
REQ-023 DECODE with dec_done=1 and halt=1: next state HALTED, pc unchanged; halt has priority over jmp_en.
REQ-024 DECODE with dec_done=1, halt=0, jmp_en=1: pc <= jmp_target, jmp_count increments, next state FETCH.
REQ-025 DECODE with dec_done=1, halt=0, jmp_en=0: pc <= pc+1 modulo 2^ADDR_W (all-ones wraps to 0), next state FETCH.
REQ-026 jmp_count saturates at 2^CNT_W-1; further taken jumps leave it unchanged.
REQ-027 HALTED: halted=1, fetch_req=0, instr_valid=0; exit only by rst.
REQ-028 fetch_ack outside FETCH and dec_done outside DECODE are ignored, with no state, pc or counter change.
REQ-029 Minimum instruction period is 2 cycles (fetch_ack and dec_done each asserted on first opportunity).

Reset
REQ-030 rst=1 at a rising edge, in any state including mid-fetch or mid-decode, sets state=IDLE, pc=RESET_PC, jmp_count=0, link_addr=0.
REQ-031 While in reset and the cycle after: fetch_req=0, instr_valid=0, halted=0, fetch_addr=RESET_PC.
REQ-032 First fetch_req=1 occurs in the second cycle after rst deasserts (IDLE then FETCH).

Configuration
REQ-033 Macro PC_SEQ_LINK_EN defined: on a taken jump (REQ-024) with link_req=1, link_addr <= pc+1 modulo 2^ADDR_W in the same edge as the pc load; otherwise link_addr holds.
REQ-034 Macro PC_SEQ_LINK_EN undefined: link_req ignored, link_addr constant 0, no link register synthesised.

Verification
REQ-035 Reset release, ADDR_W=8, RESET_PC=0x10 -> cycle 1 IDLE fetch_req=0; cycle 2 fetch_req=1, fetch_addr=0x10.
REQ-036 pc=0xFF, fetch_ack, then dec_done with jmp_en=0 -> pc=0x00, fetch_req=1, jmp_count unchanged.
REQ-037 pc=0x20, dec_done with jmp_en=1, jmp_target=0x05, link_req=1 -> pc=0x05, jmp_count+1; link_addr=0x21 with PC_SEQ_LINK_EN, 0x00 without.
REQ-038 dec_done with halt=1 and jmp_en=1 at pc=0x30 -> halted=1, pc=0x30, jmp_count unchanged; further fetch_ack/dec_done pulses no effect until rst.
REQ-039 rst asserted in DECODE with dec_done=1, jmp_en=1 the same edge -> state IDLE, pc=RESET_PC, jmp_count=0; jump discarded.
REQ-040 CNT_W=2, five taken jumps -> jmp_count 1,2,3,3,3.
